ami_w: RTL

- AXI4 master write interface for a single clock domain. It is the initiator counterpart to the slave write interface.
- It accepts write commands and a data stream from user logic and drives the AW, W and B channels toward an AXI slave.
- It generates WLAST itself, limits the number of outstanding bursts, and returns write responses to the user through a registered stage.

---
 rtl/ami_w.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ami_w.sv
// AXI4 master write interface: user command/data/response ports to AW/W/B, with internal WLAST and an outstanding-burst limit.
// Optional 4KB-boundary command check is compiled in with `define AMI_4KB_CHECK_EN.
module ami_w #(
   parameter int AXI_DW     = 128,
   parameter int AXI_AW     = 32,
   parameter int AXI_IW     = 8,
   parameter int AXI_LW     = 8,
   parameter int AXI_SW     = 3,
   parameter int AMI_OD     = 4,
   parameter int AXI_WSTRBW = AXI_DW/8
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic                  usr_wcmd_valid,
   output logic                  usr_wcmd_ready,
   input  logic [AXI_IW-1:0]     usr_wcmd_id,
   input  logic [AXI_AW-1:0]     usr_wcmd_addr,
   input  logic [AXI_LW-1:0]     usr_wcmd_len,
   input  logic [AXI_SW-1:0]     usr_wcmd_size,
   input  logic [1:0]            usr_wcmd_burst,
   output logic                  usr_wcmd_err,
   input  logic [AXI_DW-1:0]     usr_wdata,
   input  logic [AXI_WSTRBW-1:0] usr_wstrb,
   input  logic                  usr_wvalid,
   output logic                  usr_wready,
   output logic                  usr_bvalid,
   output logic [AXI_IW-1:0]     usr_bid,
   output logic [1:0]            usr_bresp,
   input  logic                  usr_bready,
   output logic [AXI_IW-1:0]     AWID,
   output logic [AXI_AW-1:0]     AWADDR,
   output logic [AXI_LW-1:0]     AWLEN,
   output logic [AXI_SW-1:0]     AWSIZE,
   output logic [1:0]            AWBURST,
   output logic                  AWVALID,
   input  logic                  AWREADY,
   output logic [AXI_DW-1:0]     WDATA,
   output logic [AXI_WSTRBW-1:0] WSTRB,
   output logic                  WLAST,
   output logic                  WVALID,
   input  logic                  WREADY,
   input  logic [AXI_IW-1:0]     BID,
   input  logic [1:0]            BRESP,
   input  logic                  BVALID,
   output logic                  BREADY
);

   localparam int AI = $clog2(AMI_OD);
   localparam int PW = AI + 1;

   // Valid/ready: a transfer happens on any rising ACLK where valid and ready are both 1;
   // a source holds valid and its payload stable until that transfer.

   typedef enum logic {W_IDLE, W_BURST} w_state_t;

   w_state_t          w_state_q, w_state_d;
   logic [PW-1:0]     os_cnt;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [AXI_LW-1:0] len_mem [AMI_OD];
   logic [AXI_LW-1:0] len_r, beat_cnt;
   logic              cmd_acc, cmd_issue, b_hs, w_hs, w_last, fifo_empty, fifo_pop;

   assign cmd_acc        = usr_wcmd_valid & usr_wcmd_ready;
   assign usr_wcmd_ready = (~AWVALID | AWREADY) & (os_cnt < PW'(AMI_OD));
   assign b_hs           = BVALID & BREADY;
   assign BREADY         = ~usr_bvalid | usr_bready;

`ifdef AMI_4KB_CHECK_EN
   logic [AXI_AW-1:0] cmd_bytes, cmd_end;
   logic              cmd_cross, err_r;

   assign cmd_bytes = (AXI_AW'(usr_wcmd_len) + AXI_AW'(1)) << usr_wcmd_size;
   assign cmd_end   = usr_wcmd_addr + cmd_bytes - AXI_AW'(1);
   assign cmd_cross = (usr_wcmd_burst == 2'b01) &&
                      (cmd_end[AXI_AW-1:12] != usr_wcmd_addr[AXI_AW-1:12]);
   assign cmd_issue = cmd_acc & ~cmd_cross;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) err_r <= 1'b0;
      else          err_r <= cmd_acc & cmd_cross;
   end
   assign usr_wcmd_err = err_r;
`else
   assign cmd_issue    = cmd_acc;
   assign usr_wcmd_err = 1'b0;
`endif

   // AW register: a fresh issue in the AWREADY cycle reloads without a bubble.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         AWVALID <= 1'b0;
         AWID    <= '0;
         AWADDR  <= '0;
         AWLEN   <= '0;
         AWSIZE  <= '0;
         AWBURST <= '0;
      end else if (cmd_issue) begin
         AWVALID <= 1'b1;
         AWID    <= usr_wcmd_id;
         AWADDR  <= usr_wcmd_addr;
         AWLEN   <= usr_wcmd_len;
         AWSIZE  <= usr_wcmd_size;
         AWBURST <= usr_wcmd_burst;
      end else if (AWREADY) begin
         AWVALID <= 1'b0;
      end
   end

   // A B response with nothing outstanding is still forwarded, but the count stays at zero.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         os_cnt <= '0;
      end else if (cmd_issue && !b_hs) begin
         os_cnt <= os_cnt + PW'(1);
      end else if (!cmd_issue && b_hs && os_cnt != '0) begin
         os_cnt <= os_cnt - PW'(1);
      end
   end

   // Burst-length FIFO; occupancy never exceeds os_cnt, so no full check is needed.
   assign fifo_empty = (wr_ptr == rd_ptr);

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (cmd_issue) wr_ptr <= wr_ptr + PW'(1);
         if (fifo_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge ACLK) begin
      if (cmd_issue) len_mem[wr_ptr[AI-1:0]] <= usr_wcmd_len;
   end

   assign w_hs   = (w_state_q == W_BURST) & usr_wvalid & WREADY;
   assign w_last = (beat_cnt == len_r);
   assign WDATA  = usr_wdata;
   assign WSTRB  = usr_wstrb;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) w_state_q <= W_IDLE;
      else          w_state_q <= w_state_d;
   end

   always_comb begin
      w_state_d  = w_state_q;
      fifo_pop   = 1'b0;
      WVALID     = 1'b0;
      WLAST      = 1'b0;
      usr_wready = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               w_state_d = W_BURST;
            end
         end
         W_BURST: begin
            WVALID     = usr_wvalid;
            usr_wready = WREADY;
            WLAST      = w_last;
            if (w_hs && w_last) begin
               if (!fifo_empty) fifo_pop  = 1'b1;
               else             w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         len_r    <= '0;
         beat_cnt <= '0;
      end else if (fifo_pop) begin
         len_r    <= len_mem[rd_ptr[AI-1:0]];
         beat_cnt <= '0;
      end else if (w_hs) begin
         beat_cnt <= beat_cnt + AXI_LW'(1);
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         usr_bvalid <= 1'b0;
         usr_bid    <= '0;
         usr_bresp  <= '0;
      end else if (b_hs) begin
         usr_bvalid <= 1'b1;
         usr_bid    <= BID;
         usr_bresp  <= BRESP;
      end else if (usr_bready) begin
         usr_bvalid <= 1'b0;
      end
   end

endmodule
